// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP adder pipeline.
// Operand widths, alignment shift limits and the exponent-align result bundle.
package fp_add_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int MANT_W_DEF = 24;

    // Past mantissa + guard + round every bit is lost, so the shift clamps here.
    function automatic int sat_of(input int mant_w);
        return mant_w + 2;
    endfunction

    function automatic int sh_w_of(input int mant_w);
        return $clog2(mant_w + 3);
    endfunction

    localparam int SAT_DEF  = sat_of(MANT_W_DEF);
    localparam int SH_W_DEF = sh_w_of(MANT_W_DEF);

    typedef struct packed {
        logic                  sel_c;
        logic [EXP_W_DEF-1:0]  exp_out;
        logic [MANT_W_DEF-1:0] mant_big;
        logic [MANT_W_DEF-1:0] mant_small;
        logic [SH_W_DEF-1:0]   shift_amt;
    } align_t;

    localparam int ALIGN_W = $bits(align_t);

endpackage

// File: rtl/fp_skid_buf.sv
// Two-entry valid/ready register slice: output register plus one skid entry.
// in_ready is registered so there is no combinational path from out_ready.
module fp_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;

    assign in_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            unique case (1'b1)
                skid_valid: begin
                    if (out_ready) begin
                        out_data   <= skid_data;
                        skid_valid <= 1'b0;
                    end
                end
                (!skid_valid && (!out_valid || out_ready)): begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        out_data <= in_data;
                    end
                end
                (!skid_valid && out_valid && !out_ready): begin
                    if (in_valid) begin
                        skid_data  <= in_data;
                        skid_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fp_exp_align_stage.sv
// FP adder exponent compare/select stage: picks the larger operand and a
// saturated alignment shift, registered behind a skid-buffered handshake.
module fp_exp_align_stage
    import fp_add_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXP_W-1:0]             exp_a,
    input  logic [EXP_W-1:0]             exp_b,
    input  logic [MANT_W-1:0]            mant_a,
    input  logic [MANT_W-1:0]            mant_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sel_c,
    output logic [EXP_W-1:0]             exp_out,
    output logic [MANT_W-1:0]            mant_big,
    output logic [MANT_W-1:0]            mant_small,
    output logic [sh_w_of(MANT_W)-1:0]   shift_amt
);

    localparam int SAT   = sat_of(MANT_W);
    localparam int SH_W  = sh_w_of(MANT_W);
    localparam int RES_W = 1 + EXP_W + 2 * MANT_W + SH_W;

    localparam logic [EXP_W:0]  SAT_E = (EXP_W + 1)'(SAT);
    localparam logic [SH_W-1:0] SAT_S = SH_W'(SAT);

    logic              sel;
    logic [EXP_W:0]    diff;
    logic [SH_W-1:0]   sh;
    logic [RES_W-1:0]  res_in;
    logic [RES_W-1:0]  res_out;

    always_comb begin
        sel  = (exp_b > exp_a) || ((exp_b == exp_a) && (mant_b > mant_a));
        // One extra bit keeps the magnitude exact before clamping.
        diff = sel ? ({1'b0, exp_b} - {1'b0, exp_a})
                   : ({1'b0, exp_a} - {1'b0, exp_b});
        sh   = (diff > SAT_E) ? SAT_S : diff[SH_W-1:0];
    end

    assign res_in = {
        sel,
        sel ? exp_b  : exp_a,
        sel ? mant_b : mant_a,
        sel ? mant_a : mant_b,
        sh
    };

    fp_skid_buf #(
        .W (RES_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (res_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (res_out)
    );

    assign {sel_c, exp_out, mant_big, mant_small, shift_amt} = res_out;

endmodule
